// File: rtl/fft_frame_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fft_frame_ctrl_pkg
//
// Constants and types shared by the 32-point FFT frame sequencer and the
// blocks around it (the twiddle ROM counts beats with the same width).
//
//   NBEAT     beats per frame: 4 samples per beat, 32 points
//   BEAT_W    width of the beat index; must match the twiddle ROM counter
//   LAST_BEAT index of the final beat in a frame
//   FRAME_W   width of the completed-frame counter
//   out_tag_t the {valid, last} pair carried down the latency-matching line
// -----------------------------------------------------------------------------
package fft_frame_ctrl_pkg;

  localparam int NBEAT   = 8;
  localparam int BEAT_W  = $clog2(NBEAT);
  localparam int FRAME_W = 16;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEAT - 1);

  // Tag that travels alongside each beat through the butterfly datapath.
  typedef struct packed {
    logic valid;
    logic last;
  } out_tag_t;

  // True on the beat that closes a frame.
  function automatic logic is_last_beat(input logic [BEAT_W-1:0] b);
    return b == LAST_BEAT;
  endfunction

endpackage

// File: rtl/fft_vdelay.sv
// -----------------------------------------------------------------------------
// fft_vdelay
//
// LAT-deep, W-bit-wide delay line. A value presented on din in cycle t is
// visible on dout in cycle t+LAT. Used to line up the output valid/last tags
// with the fixed-latency butterfly datapath.
//
// Parameters
//   LAT    delay in clock cycles (1..16)
//   W      data width (2 for the {valid, last} tag)
// Ports
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset; clears every stage
//   din    value entering the line
//   dout   value leaving the line, LAT cycles later
// -----------------------------------------------------------------------------
module fft_vdelay #(
  parameter int LAT = 4,
  parameter int W   = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] pipe_q [LAT];
  logic [W-1:0] pipe_d [LAT];

  always_comb begin
    pipe_d[0] = din;
    for (int i = 1; i < LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // NOTE: this array is a delay line of valid tags, not data storage, so every
  // stage is reset; otherwise stale bits could raise OUT_VALID after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign dout = pipe_q[LAT-1];

endmodule

// File: rtl/fft_frame_ctrl.sv
// -----------------------------------------------------------------------------
// fft_frame_ctrl
//
// Frame sequencer for the 32-point pipelined FFT. Accepts 4-sample beats on a
// valid/ready handshake, pulses START to the twiddle ROM so that beat k of a
// frame meets twiddle group k, drives the butterfly enable and beat index,
// and tracks beats through the fixed-latency datapath to produce the output
// valid/last flags.
//
// Sequence: IDLE -> PRIME (START pulse) -> WAIT (ROM registers group 0) ->
// RUN (one beat per cycle, beat index wraps 7->0 with the ROM counter).
//
// Parameters
//   LAT        butterfly datapath latency, accepted beat to result (1..16)
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   source has a beat (held until accepted)
//   in_ready   controller accepts a beat this cycle
//   tw_start   one-cycle START pulse to the twiddle ROM
//   bf_en      butterfly enable, in_valid & in_ready
//   beat       index of the current beat, 0..7
//   out_valid  datapath result valid (bf_en delayed LAT cycles)
//   out_last   last beat of a frame at the output (delayed LAT cycles)
//   busy       sequencer is not idle
//   err        sticky underrun flag
//   err_clr    clears err (a simultaneous underrun wins)
//   frame_cnt  completed input frames, wraps 65535 -> 0
// -----------------------------------------------------------------------------
module fft_frame_ctrl
  import fft_frame_ctrl_pkg::*;
#(
  parameter int LAT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               tw_start,
  output logic               bf_en,
  output logic [BEAT_W-1:0]  beat,
  output logic               out_valid,
  output logic               out_last,
  output logic               busy,
  output logic               err,
  input  logic               err_clr,
  output logic [FRAME_W-1:0] frame_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_WAIT  = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  state_t               state_q,     state_d;
  logic [BEAT_W-1:0]    beat_q,      beat_d;
  logic [FRAME_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic                 err_q,       err_d;
  logic                 in_ready_q,  in_ready_d;
  logic                 tw_start_q,  tw_start_d;
  logic                 busy_q,      busy_d;
  logic                 underrun;

  // ---------------------------------------------------------------------------
  // Next-state logic. The registered outputs are decoded from the next state
  // so that they line up with the state they describe.
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    frame_cnt_d = frame_cnt_q;
    underrun    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_PRIME;
        end
      end

      S_PRIME: begin
        state_d = S_WAIT;
      end

      // The ROM registers group 0 during this cycle; RUN starts on beat 0.
      S_WAIT: begin
        state_d = S_RUN;
        beat_d  = '0;
      end

      S_RUN: begin
        if (in_valid) begin
          // Beat accepted. The index wraps 7->0 in step with the ROM's
          // free-running counter, so back-to-back frames need no new START.
          beat_d = beat_q + 1'b1;
          if (is_last_beat(beat_q)) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end else begin
          // A missing beat on a frame boundary is a clean end of stream;
          // anywhere else the partial frame is abandoned and flagged.
          state_d  = S_IDLE;
          beat_d   = '0;
          underrun = (beat_q != '0);
        end
      end

      default: begin
        state_d = S_IDLE;
        beat_d  = '0;
      end
    endcase

    // Set has priority over clear so an underrun is never lost.
    err_d      = underrun | (err_q & ~err_clr);

    in_ready_d = (state_d == S_RUN);
    tw_start_d = (state_d == S_PRIME);
    busy_d     = (state_d != S_IDLE);
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      beat_q      <= '0;
      frame_cnt_q <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      tw_start_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      frame_cnt_q <= frame_cnt_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      tw_start_q  <= tw_start_d;
      busy_q      <= busy_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Butterfly enable and output tracking. Beats already accepted before an
  // underrun keep flowing through the delay line and still emerge.
  // ---------------------------------------------------------------------------
  out_tag_t tag_in;
  out_tag_t tag_out;

  assign bf_en        = in_valid & in_ready_q;
  assign tag_in.valid = bf_en;
  assign tag_in.last  = bf_en & is_last_beat(beat_q);

  fft_vdelay #(
    .LAT (LAT),
    .W   (2)
  ) u_vdelay (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (tag_in),
    .dout  (tag_out)
  );

  assign in_ready  = in_ready_q;
  assign tw_start  = tw_start_q;
  assign beat      = beat_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign frame_cnt = frame_cnt_q;
  assign out_valid = tag_out.valid;
  assign out_last  = tag_out.last;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fft_frame_ctrl
//
// Directed bench for the FFT frame sequencer with LAT=4. Cycle 0 of a stream
// is the cycle in which in_valid is first driven high; outputs are sampled
// 1 ns after the falling edge, inputs change on the falling edge.
// Observed outputs are packed as {tw_start, in_ready, bf_en, beat[2:0],
// out_valid, out_last, busy, err}.
// -----------------------------------------------------------------------------
module tb_fft_frame_ctrl;

  localparam int LAT  = 4;
  localparam int MAXC = 64;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        in_valid = 1'b0;
  logic        err_clr  = 1'b0;
  logic        in_ready, tw_start, bf_en, out_valid, out_last, busy, err;
  logic [2:0]  beat;
  logic [15:0] frame_cnt;

  int checks   = 0;
  int failures = 0;

  logic [9:0]  obs_v  [MAXC];
  logic [15:0] obs_fc [MAXC];

  always #5 clk = ~clk;

  fft_frame_ctrl #(
    .LAT (LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .tw_start  (tw_start),
    .bf_en     (bf_en),
    .beat      (beat),
    .out_valid (out_valid),
    .out_last  (out_last),
    .busy      (busy),
    .err       (err),
    .err_clr   (err_clr),
    .frame_cnt (frame_cnt)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [9:0] pack(input logic tw, input logic rdy, input logic bf,
                                      input logic [2:0] b, input logic ov, input logic ol,
                                      input logic bs, input logic er);
    return {tw, rdy, bf, b, ov, ol, bs, er};
  endfunction

  function automatic logic [9:0] now_vec();
    return pack(tw_start, in_ready, bf_en, beat, out_valid, out_last, busy, err);
  endfunction

  task automatic do_reset();
    in_valid = 1'b0;
    err_clr  = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // in_valid high for cycles 0..v-1; err_clr high in cycles clr_a and clr_b.
  task automatic run_stream(input int v, input int ncyc, input int clr_a, input int clr_b);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      in_valid = (c < v);
      err_clr  = (c == clr_a) || (c == clr_b);
      #1;
      obs_v[c]  = now_vec();
      obs_fc[c] = frame_cnt;
    end
    in_valid = 1'b0;
    err_clr  = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (now_vec() !== 10'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b expected=%b", now_vec(), 10'b0);
    end
    checks++;
    if (frame_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_frame_cnt got=%0d expected=0", frame_cnt);
    end
  endtask

  // One frame: beats accepted in cycles 3..10, clean end at cycle 11 (beat 0).
  task automatic test_single_frame();
    logic [9:0] exp_v;
    do_reset();
    run_stream(11, 18, -1, -1);
    for (int c = 0; c < 18; c++) begin
      exp_v = pack(c == 1, c >= 3 && c <= 11, c >= 3 && c <= 10,
                   (c >= 3 && c <= 10) ? 3'(c - 3) : 3'd0,
                   c >= 7 && c <= 14, c == 14, c >= 1 && c <= 11, 1'b0);
      checks++;
      if (obs_v[c] !== exp_v) begin
        failures++;
        $display("FAIL single_frame cyc=%0d {tw,rdy,bf,beat,ov,ol,busy,err} got=%b expected=%b",
                 c, obs_v[c], exp_v);
      end
    end
    checks++;
    if (obs_fc[10] !== 16'd0) begin
      failures++;
      $display("FAIL single_frame_cnt_early got=%0d expected=0", obs_fc[10]);
    end
    checks++;
    if (obs_fc[17] !== 16'd1) begin
      failures++;
      $display("FAIL single_frame_cnt got=%0d expected=1", obs_fc[17]);
    end
  endtask

  // Three frames: beats in cycles 3..26 with one START, clean end at cycle 27.
  task automatic test_back_to_back();
    logic [9:0] exp_v;
    do_reset();
    run_stream(27, 34, -1, -1);
    for (int c = 0; c < 34; c++) begin
      exp_v = pack(c == 1, c >= 3 && c <= 27, c >= 3 && c <= 26,
                   (c >= 3 && c <= 26) ? 3'((c - 3) % 8) : 3'd0,
                   c >= 7 && c <= 30, c == 14 || c == 22 || c == 30,
                   c >= 1 && c <= 27, 1'b0);
      checks++;
      if (obs_v[c] !== exp_v) begin
        failures++;
        $display("FAIL back_to_back cyc=%0d {tw,rdy,bf,beat,ov,ol,busy,err} got=%b expected=%b",
                 c, obs_v[c], exp_v);
      end
    end
    checks++;
    if (obs_fc[33] !== 16'd3) begin
      failures++;
      $display("FAIL back_to_back_cnt got=%0d expected=3", obs_fc[33]);
    end
  endtask

  // Beats 0..3 in cycles 3..6, in_valid low at beat 4 (cycle 7): underrun.
  task automatic test_underrun();
    logic [9:0] exp_v;
    do_reset();
    run_stream(7, 14, -1, -1);
    for (int c = 0; c < 14; c++) begin
      exp_v = pack(c == 1, c >= 3 && c <= 7, c >= 3 && c <= 6,
                   (c >= 3 && c <= 7) ? 3'(c - 3) : 3'd0,
                   c >= 7 && c <= 10, 1'b0, c >= 1 && c <= 7, c >= 8);
      checks++;
      if (obs_v[c] !== exp_v) begin
        failures++;
        $display("FAIL underrun cyc=%0d {tw,rdy,bf,beat,ov,ol,busy,err} got=%b expected=%b",
                 c, obs_v[c], exp_v);
      end
    end
    checks++;
    if (obs_fc[13] !== 16'd0) begin
      failures++;
      $display("FAIL underrun_cnt got=%0d expected=0", obs_fc[13]);
    end
  endtask

  // Runs with err still set from test_underrun. Underrun at beat 2 (cycle 5)
  // coincides with err_clr: err must stay set. err_clr at cycle 9 clears it.
  task automatic test_err_set_wins();
    logic [9:0] exp_v;
    run_stream(5, 14, 5, 9);
    for (int c = 0; c < 14; c++) begin
      exp_v = pack(c == 1, c >= 3 && c <= 5, c >= 3 && c <= 4,
                   (c >= 3 && c <= 5) ? 3'(c - 3) : 3'd0,
                   c >= 7 && c <= 8, 1'b0, c >= 1 && c <= 5, c <= 9);
      checks++;
      if (obs_v[c] !== exp_v) begin
        failures++;
        $display("FAIL err_set_wins cyc=%0d {tw,rdy,bf,beat,ov,ol,busy,err} got=%b expected=%b",
                 c, obs_v[c], exp_v);
      end
    end
    checks++;
    if (obs_fc[13] !== 16'd0) begin
      failures++;
      $display("FAIL err_set_wins_cnt got=%0d expected=0", obs_fc[13]);
    end
  endtask

  // A clean end followed by a new stream must issue a fresh START.
  task automatic test_restart();
    logic [9:0] exp_v;
    do_reset();
    run_stream(11, 16, -1, -1);
    run_stream(11, 18, -1, -1);
    for (int c = 0; c < 18; c++) begin
      exp_v = pack(c == 1, c >= 3 && c <= 11, c >= 3 && c <= 10,
                   (c >= 3 && c <= 10) ? 3'(c - 3) : 3'd0,
                   c >= 7 && c <= 14, c == 14, c >= 1 && c <= 11, 1'b0);
      checks++;
      if (obs_v[c] !== exp_v) begin
        failures++;
        $display("FAIL restart cyc=%0d {tw,rdy,bf,beat,ov,ol,busy,err} got=%b expected=%b",
                 c, obs_v[c], exp_v);
      end
    end
    checks++;
    if (obs_fc[17] !== 16'd2) begin
      failures++;
      $display("FAIL restart_cnt got=%0d expected=2", obs_fc[17]);
    end
  endtask

  // Reset asserted between clock edges at beat 5 (cycle 8), then restart.
  task automatic test_reset_mid_run();
    logic [9:0] exp_r [5];
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
    end
    #1;
    checks++;
    if (beat !== 3'd5 || in_ready !== 1'b1 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL mid_run_pre beat=%0d rdy=%b ov=%b expected beat=5 rdy=1 ov=1",
               beat, in_ready, out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (now_vec() !== 10'b0 || frame_cnt !== 16'd0) begin
      failures++;
      $display("FAIL mid_run_async_reset got=%b cnt=%0d expected=%b cnt=0",
               now_vec(), frame_cnt, 10'b0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_r[1] = pack(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    exp_r[2] = pack(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    exp_r[3] = pack(1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    exp_r[4] = pack(1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (now_vec() !== exp_r[c]) begin
        failures++;
        $display("FAIL mid_run_restart cyc=%0d {tw,rdy,bf,beat,ov,ol,busy,err} got=%b expected=%b",
                 c, now_vec(), exp_r[c]);
      end
    end
    in_valid = 1'b0;
  endtask

  // The counter is preloaded to 65535 instead of streaming 65535 frames;
  // the next completed frame must wrap it to 0.
  task automatic test_frame_wrap();
    do_reset();
    force dut.frame_cnt_q = 16'hFFFF;
    repeat (2) @(negedge clk);
    release dut.frame_cnt_q;
    run_stream(11, 14, -1, -1);
    checks++;
    if (obs_fc[10] !== 16'hFFFF) begin
      failures++;
      $display("FAIL wrap_before got=%h expected=ffff", obs_fc[10]);
    end
    checks++;
    if (obs_fc[11] !== 16'h0000) begin
      failures++;
      $display("FAIL wrap_after got=%h expected=0000", obs_fc[11]);
    end
    checks++;
    if (obs_fc[13] !== 16'h0000) begin
      failures++;
      $display("FAIL wrap_hold got=%h expected=0000", obs_fc[13]);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_underrun();
    test_err_set_wins();
    test_restart();
    test_reset_mid_run();
    test_frame_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fft_frame_ctrl.md
# fft_frame_ctrl

Frame sequencer for the 32-point pipelined FFT. It accepts 4-sample input beats over a valid/ready handshake and issues the START pulse to the twiddle ROM so each beat meets its twiddle group. It drives the butterfly enable and beat index, and tracks frames through the fixed-latency datapath to produce output valid/last. It sits between the sample source and the butterfly stage, alongside the twiddle ROM.

## Interface
- NBEAT, 8: beats per frame (4 samples per beat, 32 points); must match the twiddle ROM 3-bit counter.
- LAT, 4: butterfly datapath latency in cycles from accepted beat to result; valid range 1..16.
- CLK input 1: clock, all logic on rising edge.
- RST input 1: reset; asynchronous and active-low.
- IN_VALID input 1: source has a beat; source holds it until accepted.
- IN_READY output 1: controller accepts beat this cycle.
- TW_START output 1: one-cycle START pulse to the twiddle ROM.
- BF_EN output 1: butterfly enable, equals IN_VALID & IN_READY.
- BEAT output 3: beat index of the current accepted beat, 0..7.
- OUT_VALID output 1: datapath result valid, BF_EN delayed LAT cycles.
- OUT_LAST output 1: last beat of a frame at the output, delayed LAT cycles.
- BUSY output 1: state is not IDLE.
- ERR output 1: sticky underrun flag.
- ERR_CLR input 1: clears ERR.
- FRAME_CNT output 16: completed input frames, wraps at 65535 -> 0.

## Operation
- States: IDLE, PRIME, WAIT, RUN; state register resets to IDLE.
- IDLE: IN_READY=0. IN_VALID=1 moves to PRIME.
- PRIME: TW_START=1 for exactly this cycle. Always moves to WAIT.
- WAIT: one cycle while the ROM registers beat 0. Always moves to RUN with BEAT=0.
- RUN: IN_READY=1 every cycle. BEAT advances 0..7 and wraps to 0, in lockstep with the ROM's free-running counter.
- RUN, BEAT=0 and IN_VALID=0: clean end of stream; go to IDLE; no error.
- RUN, BEAT=1..7 and IN_VALID=0 (underrun): set ERR; go to IDLE; BEAT cleared. The partial frame is dropped from FRAME_CNT, but its already-accepted beats still emerge on OUT_VALID.
- RUN, BEAT=7 accepted: FRAME_CNT+1; stay in RUN. Back-to-back frames need no new TW_START because ROM count wraps 7->0.
- ERR_CLR together with a new underrun: the set wins.
- Output tracking: LAT-deep shift register of {BF_EN, BF_EN & BEAT==7}.
- Reset values: IN_READY, TW_START, BF_EN, BEAT, OUT_VALID, OUT_LAST, BUSY, ERR, FRAME_CNT all 0; delay line cleared.
- Reset mid-frame returns to IDLE immediately. The ROM needs no reset of its counter because every frame start re-issues TW_START.

## Timing
- IN_VALID rises in IDLE at cycle n:
  - Cycle n+1: PRIME, TW_START=1.
  - Cycle n+2: WAIT.
  - Cycle n+3: RUN, IN_READY=1, BEAT=0. ROM output holds twiddle group 0 in this same cycle.
- Beat k is accepted at cycle n+3+k with ROM group k.
- OUT_VALID for a beat accepted at cycle t: asserted at cycle t+LAT.
- Minimum gap between streams: 3 idle-ready cycles (PRIME, WAIT, plus the IDLE detection cycle).
- Throughput: one beat per cycle while streaming.

## Structure
- Shared constants go in parameter.vh: sample width nb, NBEAT, beat index width.
- State encodings are local to this block.
- One sub-module, fft_vdelay: a parameterised LAT-deep, 2-bit-wide delay line with async active-low reset. It is instantiated once for OUT_VALID/OUT_LAST.

## Test plan
- Reset, then IN_VALID=1 at cycle 0:
  - TW_START=1 only at cycle 1.
  - IN_READY first at cycle 3 with BEAT=0.
  - Eight beats accepted; FRAME_CNT=1.
  - With LAT=4, OUT_VALID at cycles 7..14 and OUT_LAST at 14.
- Three frames back-to-back:
  - Single TW_START.
  - BEAT sequence 0..7 repeats with no gap.
  - FRAME_CNT=3; OUT_LAST pulses every 8 cycles.
- IN_VALID drops at BEAT=4:
  - ERR=1, state IDLE, FRAME_CNT unchanged.
  - 4 OUT_VALID pulses with no OUT_LAST.
  - ERR_CLR clears ERR the next cycle.
- IN_VALID low at BEAT=0 after a full frame: IDLE, ERR stays 0. Re-raising IN_VALID produces a new TW_START 1 cycle later.
- Assert RST mid-RUN at BEAT=5: all outputs 0 asynchronously. After release with IN_VALID=1, the sequence restarts from PRIME.
- FRAME_CNT preloaded via 65535 frames: it wraps to 0 on the next completed frame.
